// File: rtl/day10_pkg.sv
// Shared types, sizes and helpers for the day10 minimum-press solver.
package day10_pkg;

    localparam int unsigned MAX_NUM_LIGHTS    = 10;
    localparam int unsigned MAX_NUM_BUTTONS   = 13;
    localparam int unsigned MAX_NUM_BUTTONS_W = $clog2(MAX_NUM_BUTTONS + 1);
    localparam int unsigned MAX_NUM_LIGHTS_W  = $clog2(MAX_NUM_LIGHTS + 1);
    localparam int unsigned TOTAL_W           = 32;
    // Subset counter must reach 1<<MAX_NUM_BUTTONS, hence one extra bit.
    localparam int unsigned SUBSET_W          = MAX_NUM_BUTTONS + 1;
    localparam int unsigned BTN_IDX_W         = $clog2(SUBSET_W);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } solver_state_t;

    // One machine record as delivered by the input reader.
    typedef struct packed {
        logic [MAX_NUM_LIGHTS_W-1:0]                     num_lights;
        logic [MAX_NUM_LIGHTS-1:0]                       target_lights_arrangement;
        logic [MAX_NUM_BUTTONS_W-1:0]                    num_buttons;
        logic [MAX_NUM_BUTTONS-1:0][MAX_NUM_LIGHTS-1:0]  buttons;
    } day10_record_t;

    // Reflected binary Gray code of the subset counter.
    function automatic logic [SUBSET_W-1:0] gray(input logic [SUBSET_W-1:0] k);
        return k ^ (k >> 1);
    endfunction

endpackage

// File: rtl/day10_input_if.sv
// Record bus between the day10 input reader and the solver.
interface day10_input_if;
    import day10_pkg::*;

    day10_record_t rec;

    modport producer (output rec);
    modport consumer (input  rec);
endinterface

// File: rtl/day10_ctz.sv
// Combinational trailing-zero counter; an all-zero input reports index 0.
module day10_ctz #(
    parameter int unsigned WIDTH = 14,
    localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] i_value,
    output logic [IDX_W-1:0] o_index_c
);

    // Scan from the top so the lowest set bit wins.
    always_comb begin
        o_index_c = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (i_value[i]) begin
                o_index_c = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/day10_min_press_solver.sv
// Minimum button-press solver for one day10 machine record.
// Walks every button subset in Gray-code order, one subset per cycle,
// tracking the running XOR of light masks and the running press count.
// Optional feature macro: DAY10_TOTAL_ACCUM_EN adds clear_total/total_presses.
module day10_min_press_solver
    import day10_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst_n,
    day10_input_if.consumer               day10_input,
    input  logic                          input_valid,
    output logic                          solver_ready,
    output logic                          result_valid,
    output logic [MAX_NUM_BUTTONS_W-1:0]  min_presses,
    output logic                          no_solution,
    output logic                          overrun
`ifdef DAY10_TOTAL_ACCUM_EN
    ,
    input  logic                          clear_total,
    output logic [TOTAL_W-1:0]            total_presses
`endif
);

    solver_state_t r_state;
    solver_state_t w_state_next;

    logic [MAX_NUM_LIGHTS-1:0]                       r_mask;
    logic [MAX_NUM_LIGHTS-1:0]                       r_tgt;
    logic [MAX_NUM_BUTTONS-1:0][MAX_NUM_LIGHTS-1:0]  r_buttons;
    logic [MAX_NUM_BUTTONS_W-1:0]                    r_nb;
    logic [SUBSET_W-1:0]                             r_k;
    logic [MAX_NUM_LIGHTS-1:0]                       r_acc;
    logic [MAX_NUM_BUTTONS_W-1:0]                    r_pop;
    logic [MAX_NUM_BUTTONS_W-1:0]                    r_best;
    logic                                            r_found;

    logic                                            r_solver_ready;
    logic                                            r_result_valid;
    logic [MAX_NUM_BUTTONS_W-1:0]                    r_min_presses;
    logic                                            r_no_solution;
    logic                                            r_overrun;

    logic                                            w_accept;
    logic                                            w_step;
    logic                                            w_k_end;
    logic [MAX_NUM_LIGHTS_W-1:0]                     w_nl_sat;
    logic [MAX_NUM_BUTTONS_W-1:0]                    w_nb_sat;
    logic [MAX_NUM_LIGHTS-1:0]                       w_mask_in;
    logic [MAX_NUM_LIGHTS-1:0]                       w_tgt_in;
    logic [BTN_IDX_W-1:0]                            w_b;
    logic [SUBSET_W-1:0]                             w_gray;
    logic [MAX_NUM_LIGHTS-1:0]                       w_acc_next;
    logic [MAX_NUM_BUTTONS_W-1:0]                    w_pop_next;
    logic                                            w_hit;

    // Index of the button toggled by this Gray step.
    day10_ctz #(
        .WIDTH (SUBSET_W)
    ) u_ctz (
        .i_value   (r_k),
        .o_index_c (w_b)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode and datapath strobes.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_step       = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (input_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = SEARCH;
                end
            end
            SEARCH: begin
                if (w_k_end) begin
                    w_state_next = DONE;
                end else begin
                    w_step = 1'b1;
                end
            end
            DONE: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Clamp record sizes and build the active-light mask.
    always_comb begin
        w_nl_sat = (day10_input.rec.num_lights > MAX_NUM_LIGHTS_W'(MAX_NUM_LIGHTS))
                 ? MAX_NUM_LIGHTS_W'(MAX_NUM_LIGHTS) : day10_input.rec.num_lights;
        w_nb_sat = (day10_input.rec.num_buttons > MAX_NUM_BUTTONS_W'(MAX_NUM_BUTTONS))
                 ? MAX_NUM_BUTTONS_W'(MAX_NUM_BUTTONS) : day10_input.rec.num_buttons;
        w_mask_in = '0;
        for (int i = 0; i < MAX_NUM_LIGHTS; i++) begin
            w_mask_in[i] = (MAX_NUM_LIGHTS_W'(i) < w_nl_sat);
        end
        w_tgt_in = day10_input.rec.target_lights_arrangement & w_mask_in;
    end

    // One Gray-code step: toggle button b, adjust count, test for a better hit.
    always_comb begin
        w_k_end    = (r_k == (SUBSET_W'(1) << r_nb));
        w_gray     = gray(r_k);
        w_acc_next = r_acc ^ r_buttons[w_b];
        w_pop_next = w_gray[w_b] ? (r_pop + MAX_NUM_BUTTONS_W'(1))
                                 : (r_pop - MAX_NUM_BUTTONS_W'(1));
        w_hit      = ((w_acc_next & r_mask) == r_tgt) && (!r_found || (w_pop_next < r_best));
    end

    // Search datapath: capture on accept, advance on each step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mask    <= '0;
            r_tgt     <= '0;
            r_buttons <= '0;
            r_nb      <= '0;
            r_k       <= '0;
            r_acc     <= '0;
            r_pop     <= '0;
            r_best    <= '0;
            r_found   <= 1'b0;
        end else if (w_accept) begin
            r_mask    <= w_mask_in;
            r_tgt     <= w_tgt_in;
            r_buttons <= day10_input.rec.buttons;
            r_nb      <= w_nb_sat;
            r_k       <= SUBSET_W'(1);
            r_acc     <= '0;
            r_pop     <= '0;
            r_best    <= '0;
            r_found   <= (w_tgt_in == '0);
        end else if (w_step) begin
            r_k   <= r_k + SUBSET_W'(1);
            r_acc <= w_acc_next;
            r_pop <= w_pop_next;
            if (w_hit) begin
                r_best  <= w_pop_next;
                r_found <= 1'b1;
            end
        end
    end

    // Registered handshake and result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_solver_ready <= 1'b1;
            r_result_valid <= 1'b0;
            r_min_presses  <= '0;
            r_no_solution  <= 1'b0;
        end else begin
            r_solver_ready <= (w_state_next == IDLE);
            r_result_valid <= (w_state_next == DONE);
            if (w_state_next == DONE) begin
                r_min_presses <= r_found ? r_best : '0;
                r_no_solution <= !r_found;
            end
        end
    end

    // Sticky flag for records offered while busy; the record itself is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overrun <= 1'b0;
        end else if (input_valid && (r_state != IDLE)) begin
            r_overrun <= 1'b1;
        end
    end

    assign solver_ready = r_solver_ready;
    assign result_valid = r_result_valid;
    assign min_presses  = r_min_presses;
    assign no_solution  = r_no_solution;
    assign overrun      = r_overrun;

`ifdef DAY10_TOTAL_ACCUM_EN
    logic [TOTAL_W-1:0] r_total;

    // Running total of solved press counts; clear has priority over an update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_total <= '0;
        end else if (clear_total) begin
            r_total <= '0;
        end else if (r_result_valid) begin
            r_total <= r_total + TOTAL_W'(r_min_presses);
        end
    end

    assign total_presses = r_total;
`endif

endmodule

// File: tb/tb_day10_min_press_solver.sv
// Scoreboard bench for day10_min_press_solver: directed records, expected
// results queued at issue time, checked by an independent result monitor.
module tb_day10_min_press_solver;
    import day10_pkg::*;

    logic                          clk = 1'b0;
    logic                          rst_n = 1'b0;
    logic                          input_valid = 1'b0;
    logic                          solver_ready;
    logic                          result_valid;
    logic [MAX_NUM_BUTTONS_W-1:0]  min_presses;
    logic                          no_solution;
    logic                          overrun;
`ifdef DAY10_TOTAL_ACCUM_EN
    logic                          clear_total = 1'b0;
    logic [TOTAL_W-1:0]            total_presses;
`endif

    day10_input_if u_if ();

    day10_min_press_solver u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .day10_input  (u_if),
        .input_valid  (input_valid),
        .solver_ready (solver_ready),
        .result_valid (result_valid),
        .min_presses  (min_presses),
        .no_solution  (no_solution),
        .overrun      (overrun)
`ifdef DAY10_TOTAL_ACCUM_EN
        ,
        .clear_total  (clear_total),
        .total_presses(total_presses)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_mis = 0;

    typedef struct {
        int    exp_min;
        bit    exp_nosol;
        int    exp_cyc;
        string name;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input string msg);
        n_cmp++;
        n_mis++;
        $display("FAIL %s: %s", name, msg);
    endtask

    // Result monitor: every result_valid pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && result_valid) begin
            if (sb.size() == 0) begin
                fail_now("unexpected_result", $sformatf("result_valid at cycle %0d, none expected", cyc));
            end else begin
                mon_e = sb.pop_front();
                check({mon_e.name, "_min_presses"}, 32'(min_presses), 32'(mon_e.exp_min));
                check({mon_e.name, "_no_solution"}, 32'(no_solution), 32'(mon_e.exp_nosol));
                check({mon_e.name, "_latency_cycle"}, 32'(cyc), 32'(mon_e.exp_cyc));
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Offer a record once the solver is ready; optionally queue its expected result.
    task automatic issue(input day10_record_t r, input bit push, input int lat,
                         input int mn, input bit ns, input string name);
        int waited = 0;
        while (!solver_ready && waited < 20000) begin
            step(1);
            waited++;
        end
        if (!solver_ready) fail_now({name, "_ready_timeout"}, "solver_ready never rose");
        u_if.rec    = r;
        input_valid = 1'b1;
        if (push) sb.push_back('{exp_min: mn, exp_nosol: ns, exp_cyc: cyc + lat, name: name});
        step(1);
        input_valid = 1'b0;
    endtask

    // Wait for all queued results, then a few idle cycles to catch stray pulses.
    task automatic drain(input string name);
        int waited = 0;
        while (sb.size() != 0 && waited < 20000) begin
            step(1);
            waited++;
        end
        if (sb.size() != 0) begin
            fail_now({name, "_drain_timeout"}, $sformatf("%0d results still pending", sb.size()));
            sb.delete();
        end
        step(3);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_solver_ready"}, 32'(solver_ready), 32'd1);
        check({name, "_result_valid"}, 32'(result_valid), 32'd0);
        check({name, "_min_presses"},  32'(min_presses),  32'd0);
        check({name, "_no_solution"},  32'(no_solution),  32'd0);
        check({name, "_overrun"},      32'(overrun),      32'd0);
    endtask

    function automatic day10_record_t mk(input int nl, input logic [9:0] tgt, input int nb);
        day10_record_t r;
        r = '0;
        r.num_lights                = MAX_NUM_LIGHTS_W'(nl);
        r.target_lights_arrangement = tgt;
        r.num_buttons               = MAX_NUM_BUTTONS_W'(nb);
        return r;
    endfunction

    day10_record_t rec1, rec2, rec3, rec4, rec5, rec6, rec7;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rec1 = mk(4, 10'b0110, 6);
        rec1.buttons[0] = 10'b1000;
        rec1.buttons[1] = 10'b1010;
        rec1.buttons[2] = 10'b0100;
        rec1.buttons[3] = 10'b1100;
        rec1.buttons[4] = 10'b0101;
        rec1.buttons[5] = 10'b0011;

        rec2 = mk(5, 10'b01000, 5);
        rec2.buttons[0] = 10'b11101;
        rec2.buttons[1] = 10'b01100;
        rec2.buttons[2] = 10'b10001;
        rec2.buttons[3] = 10'b00111;
        rec2.buttons[4] = 10'b11110;

        rec3 = mk(4, 10'b0000, 3);
        rec3.buttons[0] = 10'b0001;
        rec3.buttons[1] = 10'b0010;
        rec3.buttons[2] = 10'b0100;

        rec4 = mk(4, 10'b0001, 1);
        rec4.buttons[0] = 10'b0010;

        rec5 = mk(4, 10'b0001, 0);

        // Target bits 3:2 lie above num_lights and must be ignored.
        rec6 = mk(2, 10'b1101, 1);
        rec6.buttons[0] = 10'b0101;

        // num_buttons 15 saturates to 13: 2^13 subsets.
        rec7 = mk(10, 10'h200, 15);
        rec7.buttons[12] = 10'h200;

        u_if.rec = '0;
        step(3);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        step(1);

        issue(rec1, 1'b1, 65,   2, 1'b0, "t1_lights4");
        issue(rec2, 1'b1, 33,   3, 1'b0, "t2_lights5");
        issue(rec3, 1'b1, 9,    0, 1'b0, "t3_zero_target");
        issue(rec4, 1'b1, 3,    0, 1'b1, "t4_unreachable");
        issue(rec5, 1'b1, 2,    0, 1'b1, "t5_no_buttons");
        issue(rec6, 1'b1, 3,    1, 1'b0, "t6_masked_bits");
        issue(rec7, 1'b1, 8193, 1, 1'b0, "t7_saturated");
        drain("directed");
        check("post_directed_overrun", 32'(overrun), 32'd0);
        check("post_directed_ready",   32'(solver_ready), 32'd1);

        // A record offered mid-search is dropped and flags overrun.
        issue(rec1, 1'b1, 65, 2, 1'b0, "ovr_original");
        step(10);
        u_if.rec    = rec3;
        input_valid = 1'b1;
        step(1);
        input_valid = 1'b0;
        check("ovr_flag_set", 32'(overrun), 32'd1);
        drain("ovr");
        check("ovr_flag_sticky", 32'(overrun), 32'd1);

        // Reset mid-search abandons the search without a result.
        issue(rec2, 1'b0, 33, 3, 1'b0, "rst_abandoned");
        step(8);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        step(2);
        rst_n = 1'b1;
        step(40);
        issue(rec1, 1'b1, 65, 2, 1'b0, "after_reset");
        drain("after_reset");

`ifdef DAY10_TOTAL_ACCUM_EN
        clear_total = 1'b1;
        step(1);
        clear_total = 1'b0;
        issue(rec1, 1'b1, 65, 2, 1'b0, "acc_t1");
        issue(rec2, 1'b1, 33, 3, 1'b0, "acc_t2");
        drain("acc");
        check("total_after_two", total_presses, 32'd5);
        clear_total = 1'b1;
        step(1);
        clear_total = 1'b0;
        check("total_after_clear", total_presses, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
